as5600_angle_tracker: RTL and testbench

- Parametrised successor to the single-turn AS5600 angle block.
- Takes raw mechanical-angle samples with a valid strobe from the I2C register reader.
- Produces a zero-referenced mechanical angle, an electrical angle, a signed multi-turn count, a windowed velocity estimate and a stale-sensor flag.
- Sits between the I2C reader and the FOC angle/Park stage.
- Zero capture is synchronous edge-detected; there is no clocking on I_init_done.

---
 rtl/as5600_angle_tracker.sv | 171 +++++++++++++++++
 tb/tb_as5600_angle_tracker.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/as5600_angle_tracker.sv
// rtl/as5600_angle_tracker.sv - zero-referenced multi-turn angle, velocity and stale tracker for AS5600 samples
module as5600_angle_tracker #(
  parameter int ANGLE_W = 12,
  parameter int POLE_W  = 6,
  parameter int TURN_W  = 16,
  parameter int VEL_W   = 16,
  parameter int VEL_WIN = 40000,
  parameter int TIMEOUT = 20000
) (
  input  logic                      I_clk,
  input  logic                      I_rst_n,
  input  logic                      I_init_done,
  input  logic [POLE_W-1:0]         I_motor_polePair,
  input  logic                      I_as5600_dir,
  input  logic [ANGLE_W-1:0]        I_angle_raw,
  input  logic                      I_angle_valid,
  output logic                      O_angle_valid,
  output logic [ANGLE_W-1:0]        O_angle_mec,
  output logic [ANGLE_W-1:0]        O_angle_ele,
  output logic signed [TURN_W-1:0]  O_turns,
  output logic signed [VEL_W-1:0]   O_velocity,
  output logic                      O_vel_valid,
  output logic                      O_zeroed,
  output logic                      O_stale
);

  localparam int WIN_CW   = (VEL_WIN > 1) ? $clog2(VEL_WIN) : 1;
  localparam int STALE_CW = $clog2(TIMEOUT + 1);
  localparam int ACC_W    = VEL_W + 2;
  localparam int PROD_W   = ANGLE_W + POLE_W;
  localparam logic [WIN_CW-1:0]          WIN_LAST  = WIN_CW'(VEL_WIN - 1);
  localparam logic [STALE_CW-1:0]        STALE_MAX = STALE_CW'(TIMEOUT);
  localparam logic signed [TURN_W-1:0]   TURN_MAX  = {1'b0, {(TURN_W-1){1'b1}}};
  localparam logic signed [TURN_W-1:0]   TURN_MIN  = {1'b1, {(TURN_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]    VEL_MAX   = {3'b000, {(VEL_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]    VEL_MIN   = {3'b111, {(VEL_W-1){1'b0}}};

  logic                       init_d, pending, have_sample;
  logic [ANGLE_W-1:0]         raw_hold, zero, prev_rel;
  logic signed [TURN_W-1:0]   turns;
  logic signed [ACC_W-1:0]    acc;
  logic [WIN_CW-1:0]          win_cnt;
  logic [STALE_CW-1:0]        stale_cnt;
  logic                       s1_valid;
  logic [ANGLE_W-1:0]         s1_rel;
  logic [POLE_W-1:0]          s1_pole;
  logic signed [TURN_W-1:0]   s1_turns;

  logic                       rise, cap_now, sample_en, win_term, d_pos, d_neg;
  logic [ANGLE_W-1:0]         zero_eff, rel, prev_eff, ele_next;
  logic signed [ANGLE_W-1:0]  d;
  logic signed [ACC_W-1:0]    d_ext, acc_next;
  logic signed [TURN_W-1:0]   turns_next;
  logic signed [VEL_W-1:0]    vel_sat;

  // A capture coincident with a sample uses that sample, so it yields rel=0.
  assign rise      = I_init_done & ~init_d;
  assign cap_now   = (I_angle_valid & (rise | pending)) | (rise & ~I_angle_valid & have_sample);
  assign zero_eff  = cap_now ? (I_angle_valid ? I_angle_raw : raw_hold) : zero;
  assign rel       = I_as5600_dir ? (zero_eff - I_angle_raw) : (I_angle_raw - zero_eff);
  assign prev_eff  = cap_now ? '0 : prev_rel;
  assign d         = rel - prev_eff;
  assign d_pos     = ~d[ANGLE_W-1] & (d != '0);
  assign d_neg     = d[ANGLE_W-1];
  assign d_ext     = {{(ACC_W-ANGLE_W){d[ANGLE_W-1]}}, d};
  assign sample_en = I_angle_valid & (O_zeroed | cap_now);
  assign win_term  = O_zeroed & ~cap_now & (win_cnt == WIN_LAST);
  assign ele_next  = ANGLE_W'(PROD_W'(s1_pole) * PROD_W'(s1_rel));
  assign O_stale   = (stale_cnt == STALE_MAX);

  always_comb begin
    turns_next = cap_now ? '0 : turns;
    if (sample_en) begin
      if (d_pos && (rel < prev_eff) && (turns_next != TURN_MAX))
        turns_next = turns_next + TURN_W'(1);
      else if (d_neg && (rel > prev_eff) && (turns_next != TURN_MIN))
        turns_next = turns_next - TURN_W'(1);
    end
  end

  // The terminal-cycle delta is excluded from the reported window and seeds the next.
  always_comb begin
    acc_next = cap_now ? '0 : acc;
    if (win_term)
      acc_next = '0;
    if (sample_en)
      acc_next = acc_next + d_ext;
  end

  always_comb begin
    if (acc > VEL_MAX)
      vel_sat = VEL_MAX[VEL_W-1:0];
    else if (acc < VEL_MIN)
      vel_sat = VEL_MIN[VEL_W-1:0];
    else
      vel_sat = acc[VEL_W-1:0];
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      init_d        <= 1'b0;
      pending       <= 1'b0;
      have_sample   <= 1'b0;
      raw_hold      <= '0;
      zero          <= '0;
      prev_rel      <= '0;
      turns         <= '0;
      acc           <= '0;
      win_cnt       <= '0;
      stale_cnt     <= '0;
      s1_valid      <= 1'b0;
      s1_rel        <= '0;
      s1_pole       <= '0;
      s1_turns      <= '0;
      O_angle_valid <= 1'b0;
      O_angle_mec   <= '0;
      O_angle_ele   <= '0;
      O_turns       <= '0;
      O_velocity    <= '0;
      O_vel_valid   <= 1'b0;
      O_zeroed      <= 1'b0;
    end else begin
      init_d  <= I_init_done;
      pending <= (pending | (rise & ~I_angle_valid & ~have_sample)) & ~cap_now;
      if (I_angle_valid) begin
        raw_hold    <= I_angle_raw;
        have_sample <= 1'b1;
      end
      if (cap_now) begin
        zero     <= zero_eff;
        O_zeroed <= 1'b1;
      end
      if (sample_en)
        prev_rel <= rel;
      else if (cap_now)
        prev_rel <= '0;
      turns <= turns_next;
      acc   <= acc_next;

      if (cap_now || win_term)
        win_cnt <= '0;
      else if (O_zeroed)
        win_cnt <= win_cnt + WIN_CW'(1);
      O_vel_valid <= win_term;
      if (win_term)
        O_velocity <= vel_sat;

      if (I_angle_valid)
        stale_cnt <= '0;
      else if (stale_cnt != STALE_MAX)
        stale_cnt <= stale_cnt + STALE_CW'(1);

      s1_valid <= sample_en;
      if (sample_en) begin
        s1_rel   <= rel;
        s1_pole  <= I_motor_polePair;
        s1_turns <= turns_next;
      end

      O_angle_valid <= s1_valid;
      if (s1_valid) begin
        O_angle_mec <= s1_rel;
        O_angle_ele <= ele_next;
        O_turns     <= s1_turns;
      end else if (cap_now) begin
        O_turns <= '0;
      end
    end
  end

endmodule

// File: tb/tb_as5600_angle_tracker.sv
// tb/tb_as5600_angle_tracker.sv - scoreboard bench for as5600_angle_tracker
module tb_as5600_angle_tracker;

  localparam int AW   = 12;
  localparam int PW   = 6;
  localparam int TW   = 4;
  localparam int VW   = 16;
  localparam int WIN  = 64;
  localparam int TO   = 40;
  localparam int AMOD = 1 << AW;
  localparam int TMAX = (1 << (TW-1)) - 1;
  localparam int TMIN = -(1 << (TW-1));
  localparam int VMAX = (1 << (VW-1)) - 1;
  localparam int VMIN = -(1 << (VW-1));

  logic                  I_clk = 1'b0;
  logic                  I_rst_n = 1'b0;
  logic                  I_init_done = 1'b0;
  logic [PW-1:0]         I_motor_polePair = 6'd7;
  logic                  I_as5600_dir = 1'b0;
  logic [AW-1:0]         I_angle_raw = '0;
  logic                  I_angle_valid = 1'b0;
  logic                  O_angle_valid;
  logic [AW-1:0]         O_angle_mec;
  logic [AW-1:0]         O_angle_ele;
  logic signed [TW-1:0]  O_turns;
  logic signed [VW-1:0]  O_velocity;
  logic                  O_vel_valid;
  logic                  O_zeroed;
  logic                  O_stale;

  as5600_angle_tracker #(
    .ANGLE_W(AW), .POLE_W(PW), .TURN_W(TW), .VEL_W(VW), .VEL_WIN(WIN), .TIMEOUT(TO)
  ) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_init_done(I_init_done),
    .I_motor_polePair(I_motor_polePair), .I_as5600_dir(I_as5600_dir),
    .I_angle_raw(I_angle_raw), .I_angle_valid(I_angle_valid),
    .O_angle_valid(O_angle_valid), .O_angle_mec(O_angle_mec), .O_angle_ele(O_angle_ele),
    .O_turns(O_turns), .O_velocity(O_velocity), .O_vel_valid(O_vel_valid),
    .O_zeroed(O_zeroed), .O_stale(O_stale)
  );

  always #5 I_clk = ~I_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { int mec; int ele; int turns; int due; } out_t;
  typedef struct { int vel; int due; } vel_t;
  out_t oq[$];
  vel_t vq[$];

  // Reference model: angles as plain integers, one update per clock edge.
  int cyc = 0;
  bit m_init_d = 0, m_have = 0, m_pend = 0, m_zeroed = 0, m_cap = 0, m_rise = 0;
  int m_hold = 0, m_zero = 0, m_prev = 0, m_turns = 0, m_sum = 0;
  int m_next_term = 0, m_cap_edge = 0, m_stale = 0, m_raw = 0, m_rel = 0, m_d = 0;

  always @(posedge I_clk) begin
    cyc = cyc + 1;
    if (!I_rst_n) begin
      m_init_d = 0; m_have = 0; m_pend = 0; m_zeroed = 0;
      m_hold = 0; m_zero = 0; m_prev = 0; m_turns = 0; m_sum = 0; m_stale = 0;
      oq.delete();
      vq.delete();
    end else begin
      m_raw  = int'(I_angle_raw);
      m_rise = I_init_done && !m_init_d;
      m_cap  = 0;
      if (I_angle_valid && (m_rise || m_pend)) begin
        m_cap = 1; m_zero = m_raw;
      end else if (m_rise && m_have) begin
        m_cap = 1; m_zero = m_hold;
      end else if (m_rise) begin
        m_pend = 1;
      end
      if (m_cap) begin
        m_pend = 0; m_zeroed = 1; m_prev = 0; m_turns = 0; m_sum = 0;
        m_next_term = cyc + WIN; m_cap_edge = cyc;
      end else if (m_zeroed && cyc == m_next_term) begin
        vq.push_back('{vel: (m_sum > VMAX) ? VMAX : (m_sum < VMIN) ? VMIN : m_sum, due: cyc});
        m_sum = 0;
        m_next_term = m_next_term + WIN;
      end
      if (I_angle_valid && m_zeroed) begin
        m_rel = I_as5600_dir ? (m_zero - m_raw + AMOD) % AMOD : (m_raw - m_zero + AMOD) % AMOD;
        m_d = m_rel - m_prev;
        if (m_d > AMOD/2 - 1) m_d = m_d - AMOD;
        if (m_d < -AMOD/2) m_d = m_d + AMOD;
        if (m_d > 0 && m_rel < m_prev && m_turns < TMAX) m_turns = m_turns + 1;
        if (m_d < 0 && m_rel > m_prev && m_turns > TMIN) m_turns = m_turns - 1;
        m_sum = m_sum + m_d;
        m_prev = m_rel;
        oq.push_back('{mec: m_rel, ele: (int'(I_motor_polePair) * m_rel) % AMOD,
                       turns: m_turns, due: cyc + 1});
      end
      if (I_angle_valid) begin
        m_hold = m_raw; m_have = 1; m_stale = 0;
      end else if (m_stale < TO) begin
        m_stale = m_stale + 1;
      end
      m_init_d = I_init_done;
    end
  end

  out_t mon_e;
  vel_t mon_v;

  always @(negedge I_clk) begin
    if (I_rst_n) begin
      if (O_angle_valid) begin
        if (oq.size() == 0) begin
          chk("unexpected_angle_valid", 1, 0);
        end else begin
          mon_e = oq.pop_front();
          chk("angle_mec", int'(O_angle_mec), mon_e.mec);
          chk("angle_ele", int'(O_angle_ele), mon_e.ele);
          chk("turns", int'(O_turns), mon_e.turns);
          chk("angle_latency", cyc, mon_e.due);
        end
      end else if (oq.size() != 0 && oq[0].due <= cyc) begin
        chk("missing_angle_valid", 0, 1);
        void'(oq.pop_front());
      end
      if (O_vel_valid) begin
        if (vq.size() == 0) begin
          chk("unexpected_vel_valid", 1, 0);
        end else begin
          mon_v = vq.pop_front();
          chk("velocity", int'(O_velocity), mon_v.vel);
          chk("vel_timing", cyc, mon_v.due);
        end
      end else if (vq.size() != 0 && vq[0].due <= cyc) begin
        chk("missing_vel_valid", 0, 1);
        void'(vq.pop_front());
      end
      chk("zeroed", int'(O_zeroed), int'(m_zeroed));
      chk("stale", int'(O_stale), (m_stale == TO) ? 1 : 0);
    end
  end

  task automatic send(input int raw);
    I_angle_raw   = raw[AW-1:0];
    I_angle_valid = 1'b1;
    @(negedge I_clk);
    I_angle_valid = 1'b0;
  endtask

  task automatic send_init(input int raw);
    I_init_done = 1'b0;
    @(negedge I_clk);
    I_init_done = 1'b1;
    send(raw);
    I_init_done = 1'b0;
  endtask

  task automatic expect_out(input string name, input int mec, input int ele, input int turns);
    int n;
    n = 0;
    do begin
      @(negedge I_clk);
      n++;
    end while (!O_angle_valid && n < 8);
    chk({name, "_latency"}, n, 1);
    chk({name, "_mec"}, int'(O_angle_mec), mec);
    chk({name, "_ele"}, int'(O_angle_ele), ele);
    chk({name, "_turns"}, int'(O_turns), turns);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int last_raw, walk, n;
    repeat (3) @(negedge I_clk);
    I_rst_n = 1'b1;

    // Edge before any sample: capture deferred to the first sample.
    @(negedge I_clk);
    I_init_done = 1'b1;
    @(negedge I_clk);
    I_init_done = 1'b0;
    chk("deferred_not_zeroed", int'(O_zeroed), 0);
    send(12'h123);
    expect_out("deferred_cap", 0, 0, 0);
    send(12'h150);
    send(12'h180);

    // Asynchronous reset while a sample is in flight.
    #1 I_rst_n = 1'b0;
    #1;
    chk("rst_angle_valid", int'(O_angle_valid), 0);
    chk("rst_mec", int'(O_angle_mec), 0);
    chk("rst_ele", int'(O_angle_ele), 0);
    chk("rst_turns", int'(O_turns), 0);
    chk("rst_velocity", int'(O_velocity), 0);
    chk("rst_vel_valid", int'(O_vel_valid), 0);
    chk("rst_zeroed", int'(O_zeroed), 0);
    chk("rst_stale", int'(O_stale), 0);
    @(negedge I_clk);
    @(negedge I_clk);
    I_rst_n = 1'b1;

    last_raw = 0;
    for (int i = 0; i < 4; i++) begin
      last_raw = int'($urandom_range(0, AMOD-1));
      send(last_raw);
    end
    @(negedge I_clk);
    chk("unzeroed_valid", int'(O_angle_valid), 0);
    chk("unzeroed_mec", int'(O_angle_mec), 0);
    I_init_done = 1'b1;
    @(negedge I_clk);
    I_init_done = 1'b0;
    chk("held_capture_zeroed", int'(O_zeroed), 1);
    send((last_raw + 12'h055) % AMOD);
    expect_out("held_zero", 12'h055, (7 * 12'h055) % AMOD, 0);

    // Zero 0x100, seven pole pairs, both directions.
    I_motor_polePair = 6'd7;
    I_as5600_dir = 1'b0;
    send_init(12'h100);
    expect_out("cap100", 0, 0, 0);
    send(12'h300);
    expect_out("dir0", 12'h200, 12'hE00, 0);
    I_as5600_dir = 1'b1;
    send(12'h300);
    expect_out("dir1", 12'hE00, 12'h200, -1);

    // Turn counting and saturation.
    I_as5600_dir = 1'b0;
    send_init(0);
    expect_out("cap0", 0, 0, 0);
    send(12'h400); send(12'h800); send(12'hC00); send(12'hFF0);
    send(12'h010);
    expect_out("fwd_wrap", 12'h010, 12'h070, 1);
    send(12'hFF0);
    expect_out("rev_wrap", 12'hFF0, 12'hF90, 0);
    for (int r = 0; r < 10; r++) begin
      send(12'h400); send(12'h800); send(12'hC00); send(12'h000);
    end
    expect_out("turn_sat", 0, 0, TMAX);

    // Velocity window: five +0x20 steps, then one in the terminal cycle.
    send_init(0);
    for (int k = 1; k <= 5; k++) send(k * 12'h020);
    n = 0;
    while (cyc != m_cap_edge + WIN - 1 && n < 4 * WIN) begin
      @(negedge I_clk);
      n++;
    end
    send(12'h0C0);
    chk("vel_valid_pulse", int'(O_vel_valid), 1);
    chk("vel_window", int'(O_velocity), 12'h0A0);
    @(negedge I_clk);
    chk("vel_valid_one_cycle", int'(O_vel_valid), 0);
    n = 0;
    do begin
      @(negedge I_clk);
      n++;
    end while (!O_vel_valid && n < WIN + 10);
    chk("vel_seeded", int'(O_velocity), 12'h020);

    // Stale timing.
    send(12'h0C0);
    repeat (TO - 1) @(negedge I_clk);
    chk("stale_before", int'(O_stale), 0);
    @(negedge I_clk);
    chk("stale_at_timeout", int'(O_stale), 1);
    send(12'h0C0);
    chk("stale_cleared", int'(O_stale), 0);

    // Capture coincident with a sample restarts everything.
    send_init(12'h7AB);
    expect_out("cap7ab", 0, 0, 0);
    n = 0;
    do begin
      @(negedge I_clk);
      n++;
    end while (!O_vel_valid && n < WIN + 10);
    chk("win_restart", n, WIN - 1);
    chk("win_restart_vel", int'(O_velocity), 0);

    // Random walk with random captures, pole and direction changes.
    walk = int'($urandom_range(0, AMOD-1));
    for (int i = 0; i < 600; i++) begin
      walk = (walk + int'($urandom_range(0, 600)) - 300 + AMOD) % AMOD;
      I_angle_raw   = walk[AW-1:0];
      I_angle_valid = ($urandom_range(0, 2) == 0);
      I_init_done   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) I_motor_polePair = PW'($urandom_range(1, 63));
      if ($urandom_range(0, 59) == 0) I_as5600_dir = ~I_as5600_dir;
      @(negedge I_clk);
    end
    I_angle_valid = 1'b0;
    I_init_done = 1'b0;
    repeat (WIN + 5) @(negedge I_clk);
    chk("drain_angle_queue", oq.size(), 0);
    chk("drain_vel_queue", vq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
